// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU datapath blocks
//   state_t       - serial-unit sequencing states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand width
package alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit full-subtractor cell, d = a - b - bin
//   a, b  - operand bits
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial K-bit subtractor, diff = a - b, LSB first
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - request, accepted whenever not busy (including the done cycle)
//   a, b       - minuend / subtrahend, captured on the accepting edge
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when diff/borrow/ovf are updated
//   diff       - a - b modulo 2^K
//   borrow     - unsigned underflow (a < b)
//   ovf        - two's-complement overflow
module serial_subtractor
    import alu_pkg::*;
#(
    parameter  int K     = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(K) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] diff,
    output logic         borrow,
    output logic         ovf
);

    state_t             state, next;
    logic [K-1:0]       a_sh, b_sh, diff_sh;
    logic               bflop;
    logic [CNT_W-1:0]   cnt;
    logic               d, bout, last, accept;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bflop),
        .d    (d),
        .bout (bout)
    );

    assign last   = (state == RUN) && (cnt == CNT_W'(K - 1));
    assign accept = start && (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    // IDLE and DONE behave identically: start loads, otherwise rest in IDLE
    always_comb begin
        next = state;
        if (state == RUN) next = last ? DONE : RUN;
        else              next = start ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            bflop   <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            borrow  <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            bflop <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= {d, diff_sh[K-1:1]};
            bflop   <= bout;
            cnt     <= cnt + CNT_W'(1);
            if (last) begin
                diff   <= {d, diff_sh[K-1:1]};
                borrow <= bout;
                // on the last bit a_sh[0]/b_sh[0] are the captured operand MSBs
                ovf    <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomised checks of serial_subtractor (K=8 and K=4)
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, busy8, done8, borrow8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start4, busy4, done4, borrow4, ovf4;
    logic [3:0] a4, b4, diff4;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.K(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8),
        .ovf    (ovf8)
    );

    serial_subtractor #(.K(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4),
        .ovf    (ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts edges until done8 rises (bounded); lat starts at lat0
    task automatic wait_done8(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc  = int'(busy8);
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            bc += int'(busy8);
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, output int lat, output int bc);
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(0, lat, bc);
    endtask

    initial begin
        int         lat, bc, sd, hits;
        logic [7:0] x, y, e;
        logic       ov;
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        #12;
        check("rst busy8",   busy8,   0);
        check("rst done8",   done8,   0);
        check("rst out8",    {borrow8, ovf8, diff8}, 0);
        check("rst out4",    {busy4, done4, borrow4, ovf4, diff4}, 0);
        @(negedge clk); rst_n = 1'b1;

        op8(8'h5A, 8'h23, lat, bc);
        check("5A-23 lat",    lat, 8);
        check("5A-23 busy",   bc, 8);
        check("5A-23 diff",   diff8, 8'h37);
        check("5A-23 borrow", borrow8, 0);
        check("5A-23 ovf",    ovf8, 0);
        @(posedge clk); #1;
        check("done pulse",   {done8, busy8}, 0);
        check("hold diff",    diff8, 8'h37);

        op8(8'h23, 8'h5A, lat, bc);
        check("23-5A", {borrow8, ovf8, diff8}, {1'b1, 1'b0, 8'hC9});
        op8(8'h80, 8'h01, lat, bc);
        check("80-01", {borrow8, ovf8, diff8}, {1'b0, 1'b1, 8'h7F});
        op8(8'h7F, 8'hFF, lat, bc);
        check("7F-FF", {borrow8, ovf8, diff8}, {1'b1, 1'b1, 8'h80});
        op8(8'h00, 8'h00, lat, bc);
        check("00-00", {borrow8, ovf8, diff8}, 0);

        // start during RUN is ignored and new a/b values are not captured
        @(negedge clk); a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        wait_done8(3, lat, bc);
        check("ign start lat",  lat, 8);
        check("ign start diff", {borrow8, ovf8, diff8}, {1'b0, 1'b0, 8'h37});

        // start held through DONE: reload with no idle cycle
        @(negedge clk); a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        wait_done8(0, lat, bc);
        check("b2b first", {borrow8, ovf8, diff8}, {1'b0, 1'b1, 8'h7F});
        @(negedge clk); a8 = 8'h10; b8 = 8'h20;
        @(posedge clk); #1; start8 = 1'b0;
        check("b2b busy",      {busy8, done8}, 2'b10);
        check("b2b hold diff", diff8, 8'h7F);
        wait_done8(0, lat, bc);
        check("b2b lat",    lat, 8);
        check("b2b second", {borrow8, ovf8, diff8}, {1'b1, 1'b0, 8'hF0});

        // reset in the middle of RUN aborts
        @(negedge clk); a8 = 8'h23; b8 = 8'h5A; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("abort out", {busy8, done8, borrow8, ovf8, diff8}, 0);
        hits = 0;
        repeat (3) begin @(posedge clk); #1; hits += int'(done8 | busy8); end
        @(negedge clk); rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; hits += int'(done8 | busy8); end
        check("abort no done", hits, 0);
        op8(8'h5A, 8'h23, lat, bc);
        check("post rst lat", lat, 8);
        check("post rst",     {borrow8, ovf8, diff8}, {1'b0, 1'b0, 8'h37});

        // K=4 instance
        @(negedge clk); a4 = 4'h3; b4 = 4'h5; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("k4 lat", lat, 4);
        check("k4 3-5", {borrow4, ovf4, diff4}, {1'b1, 1'b0, 4'hE});

        for (int i = 0; i < 1000; i++) begin
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            e  = x - y;
            sd = int'(signed'(x)) - int'(signed'(y));
            ov = (sd > 127) || (sd < -128);
            op8(x, y, lat, bc);
            check("rand lat", lat, 8);
            check("rand res", {borrow8, ovf8, diff8}, {x < y, ov, e});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial K-bit subtractor. Computes diff = a - b, LSB first, one bit per clock.
- Reuses a 1-bit full-subtractor cell with a registered borrow. It is the inverse-direction companion to the team's combinational ripple-carry adder.
- Used by the ALU datapath where area matters more than latency.
- Operands are captured on a start handshake. Results are held stable until the next accepted start.

Parameters:
- K, 8, operand/result width in bits (K >= 2).
- CNT_W, $clog2(K)+1, bit counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk while not busy.
- a  input  K  minuend; captured when start is accepted.
- b  input  K  subtrahend; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  K  a - b modulo 2^K.
- borrow  output  1  unsigned underflow (a < b).
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0.
  - Internal shift registers, borrow flop and counter all cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 -> load a_sh<=a, b_sh<=b, bflop<=0, cnt<=0; go to RUN; busy=1 after E0.
  - RUN: each edge computes one bit using the cell.
    - Cell: d = a_sh[0]^b_sh[0]^bflop; bout = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bflop).
    - d shifts into diff_sh from the MSB end; a_sh and b_sh shift right; bflop<=bout; cnt++.
  - RUN exit: the edge processing bit K-1 (edge EK) goes to DONE.
    - diff<=final diff_sh; borrow<=final bout.
    - ovf<=(a[K-1]!=b[K-1]) && (diff[K-1]!=a[K-1]), using the captured operand MSBs.
    - done=1; busy=0.
  - DONE: lasts exactly one cycle; done drops.
    - start=1 in DONE is accepted immediately (reload, go to RUN).
    - Otherwise go to IDLE.
- Latency: done is high in the cycle after edge EK, i.e. K cycles after the accepting edge. Back-to-back throughput is one result per K+1 cycles.
- Outputs diff/borrow/ovf change only at the edge that asserts done. They hold until the next done; they are not cleared by a new start.
- start while busy (RUN) is ignored. Captured operands are unaffected by a/b changes after acceptance.
- Reset mid-RUN aborts the operation. All outputs return to reset values and no done is produced.
- Equal operands give diff=0, borrow=0, ovf=0.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package alu_pkg:
  - state enum (IDLE, RUN, DONE).
  - DEFAULT_WIDTH=8.
- One natural sub-module: full_subtractor (a, b, bin -> d, bout), pure combinational, instantiated once.
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- K=8, a=0x5A, b=0x23, start for 1 cycle -> busy for 8 cycles; done pulses at cycle 8 after the accepting edge; diff=0x37, borrow=0, ovf=0.
- a=0x23, b=0x5A -> diff=0xC9, borrow=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
- a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- a=0x00, b=0x00 -> diff=0x00, borrow=0, ovf=0.
- Start pulsed at cycle 3 of RUN with different operands -> ignored; result still for the original operands.
- Start held high through DONE -> second operation begins with no idle cycle.
- rst_n asserted mid-RUN (cycle 4) -> outputs immediately 0, busy=0, no done.
- After release, a new start completes normally.
- Re-run with K=4: a=0x3, b=0x5 -> diff=0xE, borrow=1, done 4 cycles after accept.
- Bench compares every result against a behavioural a-b model over 1000 random operand pairs.
